// File: rtl/microop_sequencer.sv
// Register-file sequencer for the 4-bit logic microoperation unit.
// It accepts a load or a logic op, drives SEL/A/B into the unit, samples F and writes the result back.
module microop_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic [3:0] cmd_imm,
    output logic       SEL0,
    output logic       SEL1,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] F,
    output logic [3:0] result,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] rf_q, rf_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [3:0]      result_q, result_d;
    logic [1:0]      rd_q, rd_d;

    always_comb begin
        state_d  = state_q;
        rf_d     = rf_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_d = cmd_rd;
                    if (cmd_load) begin
                        result_d = cmd_imm;
                        state_d  = S_WB;
                    end else begin
                        // Operands are captured here, so rd may alias ra/rb without a hazard.
                        sel_d   = cmd_op;
                        a_d     = rf_q[cmd_ra];
                        b_d     = rf_q[cmd_rb];
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = F;
                state_d  = S_WB;
            end
            S_WB: begin
                rf_d[rd_q] = result_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rf_q     <= '0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rf_q     <= rf_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_WB);
    assign SEL0      = sel_q[0];
    assign SEL1      = sel_q[1];
    assign A         = a_q;
    assign B         = b_q;
    assign result    = result_q;

endmodule

// File: tb/tb_microop_sequencer.sv
// Self-checking bench for microop_sequencer: directed steps then random commands against a register-file model.
module tb_microop_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [1:0] cmd_op, cmd_ra, cmd_rb, cmd_rd;
    logic [3:0] cmd_imm;
    logic       SEL0, SEL1;
    logic [3:0] A, B, F, result;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_rf [4];
    logic [1:0] m_sel;
    logic [3:0] m_a, m_b, m_res;

    microop_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .SEL0(SEL0), .SEL1(SEL1),
        .A(A), .B(B), .F(F), .result(result), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // External combinational logic unit.
    assign F = lu({SEL1, SEL0}, A, B);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic noise(input bit noisy);
        if (noisy) begin
            cmd_valid = 1'($urandom);
            cmd_load  = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_ra    = 2'($urandom);
            cmd_rb    = 2'($urandom);
            cmd_rd    = 2'($urandom);
            cmd_imm   = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic chk_dp(input string tag);
        chk({tag, "_sel"}, {6'd0, SEL1, SEL0}, {6'd0, m_sel});
        chk({tag, "_a"}, {4'd0, A}, {4'd0, m_a});
        chk({tag, "_b"}, {4'd0, B}, {4'd0, m_b});
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
    task automatic run_cmd(input logic ld, input logic [1:0] op, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [1:0] rd, input logic [3:0] imm,
                           input bit noisy);
        chk("ready_idle", {7'd0, cmd_ready}, 8'd1);
        chk("done_idle", {7'd0, done}, 8'd0);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op;
        cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
        @(posedge clk); #1;
        noise(noisy);
        if (!ld) begin
            m_sel = op; m_a = m_rf[ra]; m_b = m_rf[rb];
            m_res = lu(op, m_a, m_b);
            @(negedge clk);
            chk("exec_ready", {7'd0, cmd_ready}, 8'd0);
            chk("exec_done", {7'd0, done}, 8'd0);
            chk_dp("exec");
            @(posedge clk); #1;
            noise(noisy);
        end else begin
            m_res = imm;
        end
        @(negedge clk);
        chk("wb_done", {7'd0, done}, 8'd1);
        chk("wb_ready", {7'd0, cmd_ready}, 8'd0);
        chk("wb_result", {4'd0, result}, {4'd0, m_res});
        chk_dp("wb");
        m_rf[rd] = m_res;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_result"}, {4'd0, result}, 8'd0);
        chk({tag, "_sel"}, {6'd0, SEL1, SEL0}, 8'd0);
        chk({tag, "_ab"}, {A, B}, 8'd0);
        chk({tag, "_ready"}, {7'd0, cmd_ready}, 8'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_sel = 2'd0; m_a = 4'd0; m_b = 4'd0; m_res = 4'd0;
    endtask

    initial begin
        // Reset with a command presented; it must be discarded.
        rst = 1'b1; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 2'd0;
        cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_rd = 2'd0; cmd_imm = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        chk_reset_state("reset");

        run_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0101, 1'b0);
        run_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd1, 4'b1011, 1'b0);
        run_cmd(1'b0, 2'b00, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
        chk("and_val", {4'd0, result}, 8'b0000_0001);
        run_cmd(1'b0, 2'b01, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
        chk("or_val", {4'd0, result}, 8'b0000_1111);
        run_cmd(1'b0, 2'b10, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
        chk("xor_val", {4'd0, result}, 8'b0000_1110);
        run_cmd(1'b0, 2'b11, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
        chk("not_val", {4'd0, result}, 8'b0000_1010);
        chk("not_b", {4'd0, B}, 8'b0000_1011);

        // Dependent back-to-back with noisy inputs while busy.
        run_cmd(1'b0, 2'b10, 2'd0, 2'd1, 2'd0, 4'd0, 1'b1);
        chk("dep_xor", {4'd0, result}, 8'b0000_1110);
        run_cmd(1'b0, 2'b00, 2'd0, 2'd1, 2'd3, 4'd0, 1'b1);
        chk("dep_and", {4'd0, result}, 8'b0000_1010);

        // Reset during EXEC aborts the op.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b00;
        cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec", {7'd0, cmd_ready}, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_state("abort");
        run_cmd(1'b0, 2'b00, 2'd0, 2'd0, 2'd1, 4'd0, 1'b0);
        chk("abort_rb", {4'd0, result}, 8'd0);

        // Random commands against the model.
        for (int n = 0; n < 60; n++) begin
            run_cmd(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), 4'($urandom), 1'($urandom));
            // Idle gap: result/datapath hold and done stays low.
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("gap_done", {7'd0, done}, 8'd0);
                chk("gap_result", {4'd0, result}, {4'd0, m_res});
            end
        end

        // Readback all registers via OR r,r.
        for (int r = 0; r < 4; r++) begin
            run_cmd(1'b0, 2'b01, 2'(r), 2'(r), 2'(r), 4'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
